hmove_entry_ctrl: RTL and testbench
===================================

// Module: hmove_entry_ctrl
// PURPOSE
//  Upstream stage of the tic-tac-toe computer-player FSM. Turns raw switch value + raw "enter" button into the
//  stable 4-bit hMove the FSM samples every clock. Synchronizes/debounces enter, validates the move against a
//  locally tracked board (human + computer cells), captures the FSM's cMove reply, and stops at game over.
// PARAMETERS
//  SYNC_STAGES      2   flops in enter synchronizer (>=2)
//  DEBOUNCE_CYCLES  16  consecutive stable cycles before debounced enter changes (>=1)
// PORTS
//  clock      in   1  single system clock, all state on posedge
//  reset      in   1  asynchronous, active-low; clears all state immediately when low
//  sw         in   4  raw move switches, cell number 1..9; sampled only on accepted press
//  enter      in   1  raw asynchronous push button, active-high
//  cMove      in   4  computer move from downstream FSM (combinational from its state)
//  win        in   1  game-won flag from downstream FSM
//  hMove      out  4  human move to FSM; held stable between accepted moves
//  moveValid  out  1  one-cycle pulse in the cycle hMove takes a new value
//  illegal    out  1  last press rejected; held until next accepted move or reset
//  board_h    out  9  human cells, bit k-1 = cell k
//  board_c    out  9  computer cells, bit k-1 = cell k
//  gameOver   out  1  high in DONE
// BEHAVIOUR
//  Reset (reset=0): hMove=0, moveValid=0, illegal=0, board_h=0, board_c=0, gameOver=0, sync/debounce=0, state=INIT.
//   hMove=0 is required: downstream FSM leaves its start state only on hMove=6.
//  Sync: enter through SYNC_STAGES flops. Debounce: counter runs while sync != debounced level, clears otherwise;
//   debounced level flips on the edge where count reaches DEBOUNCE_CYCLES. press = debounced & ~debounced_d1 (1 cycle).
//  FSM states:
//   INIT    : first cycle after reset release; capture cMove into board_c (computer moves first) -> IDLE.
//   IDLE    : press -> latch sw into cand, -> CHECK. No press -> stay.
//   CHECK   : legal iff 1<=cand<=9 and board_h[cand-1]==0 and board_c[cand-1]==0.
//             legal -> COMMIT; illegal -> illegal<=1, -> WAIT_REL.
//   COMMIT  : hMove<=cand, board_h[cand-1]<=1, illegal<=0, moveValid=1 next cycle -> CMWAIT.
//   CMWAIT  : one cycle for FSM state register to absorb hMove -> CMCAP.
//   CMCAP   : if win or cMove in 1..9 and cell free, set board_c[cMove-1]; cMove=0 or occupied cell -> board_c unchanged.
//             -> DONE if win or (board_h|board_c)==9'h1FF after update, else WAIT_REL.
//   WAIT_REL: wait for debounced enter=0 -> IDLE.
//   DONE    : gameOver=1; all presses ignored; hMove/board frozen; exit only via reset.
//  Latency: raw enter rise (held stable) -> hMove update = SYNC_STAGES + DEBOUNCE_CYCLES + 3 clocks.
//  Presses arriving outside IDLE are dropped (not queued). sw changes outside IDLE have no effect.
//  hMove never changes except in COMMIT; an illegal press leaves hMove, board_h, board_c untouched.
//  Holding enter produces exactly one press; a new press requires release via WAIT_REL.
//  Reset asserted mid-operation (any state) clears all outputs asynchronously; no partial commit survives.
// CONFIGURATION
//  MOVE_COUNT_EN defined: extra output moveCount[3:0], reset 0, +1 on each COMMIT, saturates at 9.
//  MOVE_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=16)
//  Reset release -> after INIT board_c=9'h010 (cell 5), hMove=0, illegal=0, gameOver=0.
//  sw=6, enter held 30 cycles -> hMove=6 exactly 21 clocks after rise, one moveValid pulse, board_h=9'h020, board_c=9'h011.
//  Then sw=5 press -> illegal=1, hMove stays 6, boards unchanged; then sw=0 and sw=4'hA presses -> illegal=1 each.
//  enter toggling every 3 cycles for 40 cycles -> no press, no state change; held enter 60 cycles -> single moveValid.
//  Moves 6, 9, 4 -> hMove 6,9,4; win=1 captured in CMCAP -> gameOver=1; further presses ignored.
//  reset pulled low in CHECK with sw=7 -> all outputs 0 immediately; board_h bit 6 never set.

Source files
------------

// File: rtl/hmove_entry_ctrl_if.sv
// Move-entry bus between the switch/button front end, hmove_entry_ctrl and the game FSM.
// Optional moveCount exists only when MOVE_COUNT_EN is defined.
interface hmove_entry_ctrl_if;
  logic [3:0] sw;
  logic       enter;
  logic [3:0] cMove;
  logic       win;
  logic [3:0] hMove;
  logic       moveValid;
  logic       illegal;
  logic [8:0] board_h;
  logic [8:0] board_c;
  logic       gameOver;
`ifdef MOVE_COUNT_EN
  logic [3:0] moveCount;
`endif

  // Drives raw inputs and the FSM reply, observes the controller outputs
  modport master (
    output sw, enter, cMove, win,
    input  hMove, moveValid, illegal, board_h, board_c, gameOver
`ifdef MOVE_COUNT_EN
    , input moveCount
`endif
  );

  // The controller itself
  modport slave (
    input  sw, enter, cMove, win,
    output hMove, moveValid, illegal, board_h, board_c, gameOver
`ifdef MOVE_COUNT_EN
    , output moveCount
`endif
  );
endinterface

// File: rtl/hmove_entry_ctrl.sv
// Human move entry for the tic-tac-toe player: enter sync/debounce, move legality against a local
// board copy, cMove capture and game-over stop. Define MOVE_COUNT_EN to add the moveCount output.
module hmove_entry_ctrl #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic              clock,
  input logic              reset,
  hmove_entry_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CHECK, S_COMMIT, S_CMWAIT, S_CMCAP, S_WAIT_REL, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d, deb_d1_q;
  logic                   sync_lvl, press;
  logic [3:0]             cand_q, cand_d;
  logic [3:0]             hmove_q, hmove_d;
  logic                   valid_q, valid_d;
  logic                   illegal_q, illegal_d;
  logic [8:0]             bh_q, bh_d;
  logic [8:0]             bc_q, bc_d;
  logic [8:0]             bc_next;
  logic                   go_q, go_d;
  logic [8:0]             mask_cand, mask_cmove;

  // One-hot cell mask; zero for anything outside 1..9
  function automatic logic [8:0] cell_mask(input logic [3:0] c);
    logic [8:0] m;
    m = '0;
    if (c >= 4'd1 && c <= 4'd9) m = 9'd1 << (c - 4'd1);
    return m;
  endfunction

  assign sync_lvl   = sync_q[SYNC_STAGES-1];
  assign press      = deb_q & ~deb_d1_q;
  assign mask_cand  = cell_mask(cand_q);
  assign mask_cmove = cell_mask(bus.cMove);

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_lvl != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync_lvl;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef MOVE_COUNT_EN
  logic [3:0] mc_q, mc_d;
  assign bus.moveCount = mc_q;
`endif

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    hmove_d   = hmove_q;
    valid_d   = 1'b0;
    illegal_d = illegal_q;
    bh_d      = bh_q;
    bc_d      = bc_q;
    bc_next   = bc_q;
    go_d      = go_q;
`ifdef MOVE_COUNT_EN
    mc_d      = mc_q;
`endif
    unique case (state_q)
      S_INIT: begin
        bc_d    = bc_q | mask_cmove;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (press) begin
          cand_d  = bus.sw;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mask_cand != 9'd0 && ((bh_q | bc_q) & mask_cand) == 9'd0) begin
          state_d = S_COMMIT;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_WAIT_REL;
        end
      end
      S_COMMIT: begin
        hmove_d   = cand_q;
        bh_d      = bh_q | mask_cand;
        illegal_d = 1'b0;
        valid_d   = 1'b1;
`ifdef MOVE_COUNT_EN
        if (mc_q != 4'd9) mc_d = mc_q + 4'd1;
`endif
        state_d   = S_CMWAIT;
      end
      S_CMWAIT: state_d = S_CMCAP;
      S_CMCAP: begin
        // A zero or already-occupied reply leaves the computer board alone
        if (((bh_q | bc_q) & mask_cmove) == 9'd0) bc_next = bc_q | mask_cmove;
        bc_d = bc_next;
        if (bus.win || (bh_q | bc_next) == 9'h1FF) begin
          go_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (!deb_q) state_d = S_IDLE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      sync_q    <= '0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_d1_q  <= 1'b0;
      cand_q    <= '0;
      hmove_q   <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      bh_q      <= '0;
      bc_q      <= '0;
      go_q      <= 1'b0;
`ifdef MOVE_COUNT_EN
      mc_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.enter};
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_d1_q  <= deb_q;
      cand_q    <= cand_d;
      hmove_q   <= hmove_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      bh_q      <= bh_d;
      bc_q      <= bc_d;
      go_q      <= go_d;
`ifdef MOVE_COUNT_EN
      mc_q      <= mc_d;
`endif
    end
  end

  assign bus.hMove     = hmove_q;
  assign bus.moveValid = valid_q;
  assign bus.illegal   = illegal_q;
  assign bus.board_h   = bh_q;
  assign bus.board_c   = bc_q;
  assign bus.gameOver  = go_q;

endmodule

// File: tb/tb_hmove_entry_ctrl.sv
// Scoreboard bench for hmove_entry_ctrl: accepted presses push the expected hMove/board_h/cycle,
// a monitor pops and compares on every moveValid pulse.
module tb_hmove_entry_ctrl;

  localparam int unsigned LAT = 2 + 16 + 3;

  logic clock;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  typedef struct packed {
    logic [3:0]  hm;
    logic [8:0]  bh;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb_q[$];

  hmove_entry_ctrl_if bus_if ();

  hmove_entry_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every moveValid must match the oldest expected commit
  always @(negedge clock) begin
    if (reset && bus_if.moveValid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_moveValid: got hMove=%0h with no pending commit", bus_if.hMove);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("mv_hMove", 32'(bus_if.hMove), 32'(e.hm));
        chk("mv_board_h", 32'(bus_if.board_h), 32'(e.bh));
        chk("mv_latency_cycle", 32'(cyc), e.cyc);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    bus_if.sw = 4'd0;
    bus_if.enter = 1'b0;
    bus_if.win = 1'b0;
    bus_if.cMove = 4'd5;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  // Press with sw=s held for 'hold' cycles; if ok, the commit is expected LAT clocks after the rise
  task automatic press(input logic [3:0] s, input int hold, input bit ok, input logic [8:0] exp_bh);
    exp_t e;
    bus_if.sw = s;
    @(negedge clock);
    bus_if.enter = 1'b1;
    if (ok) begin
      e.hm = s;
      e.bh = exp_bh;
      e.cyc = 32'(cyc + int'(LAT));
      sb_q.push_back(e);
    end
    repeat (hold) @(negedge clock);
    bus_if.enter = 1'b0;
    repeat (25) @(negedge clock);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    bus_if.sw = 4'd0;
    bus_if.enter = 1'b0;
    bus_if.win = 1'b0;
    bus_if.cMove = 4'd5;
    repeat (2) @(negedge clock);
    chk("rst_hMove", 32'(bus_if.hMove), 32'd0);
    chk("rst_board_c", 32'(bus_if.board_c), 32'd0);
    chk("rst_moveValid", 32'(bus_if.moveValid), 32'd0);

    // Game 1: computer opens on cell 5
    do_reset();
    chk("init_board_c", 32'(bus_if.board_c), 32'h010);
    chk("init_hMove", 32'(bus_if.hMove), 32'd0);
    chk("init_illegal", 32'(bus_if.illegal), 32'd0);
    chk("init_gameOver", 32'(bus_if.gameOver), 32'd0);

    bus_if.cMove = 4'd1;
    press(4'd6, 30, 1'b1, 9'h020);
    chk("m6_board_h", 32'(bus_if.board_h), 32'h020);
    chk("m6_board_c", 32'(bus_if.board_c), 32'h011);
    chk("m6_illegal", 32'(bus_if.illegal), 32'd0);

    // Occupied and out-of-range cells are rejected
    press(4'd5, 25, 1'b0, 9'h0);
    chk("occ_illegal", 32'(bus_if.illegal), 32'd1);
    chk("occ_hMove", 32'(bus_if.hMove), 32'd6);
    chk("occ_board_h", 32'(bus_if.board_h), 32'h020);
    chk("occ_board_c", 32'(bus_if.board_c), 32'h011);
    press(4'd0, 25, 1'b0, 9'h0);
    chk("zero_illegal", 32'(bus_if.illegal), 32'd1);
    press(4'hA, 25, 1'b0, 9'h0);
    chk("ten_illegal", 32'(bus_if.illegal), 32'd1);
    chk("ten_board_h", 32'(bus_if.board_h), 32'h020);

    // Bouncing enter never settles long enough to count as a press
    bus_if.sw = 4'd3;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) bus_if.enter = ~bus_if.enter;
      @(negedge clock);
    end
    bus_if.enter = 1'b0;
    repeat (25) @(negedge clock);
    chk("bounce_hMove", 32'(bus_if.hMove), 32'd6);
    chk("bounce_board_h", 32'(bus_if.board_h), 32'h020);

    // Long hold gives exactly one commit; reply cell 2
    bus_if.cMove = 4'd2;
    press(4'd9, 60, 1'b1, 9'h120);
    chk("hold_hMove", 32'(bus_if.hMove), 32'd9);
    chk("hold_illegal", 32'(bus_if.illegal), 32'd0);
    chk("hold_board_c", 32'(bus_if.board_c), 32'h013);

    // Game 2: moves 6, 9, 4 and a win
    do_reset();
    bus_if.cMove = 4'd1;
    press(4'd6, 30, 1'b1, 9'h020);
    bus_if.cMove = 4'd2;
    press(4'd9, 30, 1'b1, 9'h120);
    bus_if.cMove = 4'd3;
    bus_if.win = 1'b1;
    press(4'd4, 30, 1'b1, 9'h128);
    chk("win_gameOver", 32'(bus_if.gameOver), 32'd1);
    chk("win_board_c", 32'(bus_if.board_c), 32'h017);
    chk("win_hMove", 32'(bus_if.hMove), 32'd4);
    press(4'd7, 30, 1'b0, 9'h0);
    chk("done_hMove", 32'(bus_if.hMove), 32'd4);
    chk("done_board_h", 32'(bus_if.board_h), 32'h128);
    chk("done_gameOver", 32'(bus_if.gameOver), 32'd1);

    // Game 3: reset lands while move 7 is being checked
    do_reset();
    bus_if.cMove = 4'd1;
    press(4'd6, 30, 1'b1, 9'h020);
    bus_if.sw = 4'd7;
    @(negedge clock);
    bus_if.enter = 1'b1;
    repeat (19) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_hMove", 32'(bus_if.hMove), 32'd0);
    chk("midrst_board_h", 32'(bus_if.board_h), 32'd0);
    chk("midrst_board_c", 32'(bus_if.board_c), 32'd0);
    chk("midrst_illegal", 32'(bus_if.illegal), 32'd0);
    chk("midrst_gameOver", 32'(bus_if.gameOver), 32'd0);
    bus_if.enter = 1'b0;
    bus_if.cMove = 4'd0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    chk("postrst_board_h_bit6", 32'(bus_if.board_h[6]), 32'd0);
    chk("postrst_hMove", 32'(bus_if.hMove), 32'd0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
